// File: rtl/mips32_pkg.sv
// Shared pipe_MIPS32 register-file dimensions and the register dump FSM state encoding.
package mips32_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_unit_chk.sv
// Protocol checker for the reg_dump_unit streaming interface; observes ports only.
module reg_dump_unit_chk #(
  parameter int DATA_W = mips32_pkg::DATA_W,
  parameter int ADDR_W = mips32_pkg::REG_ADDR_W
) (
  input logic              clk1,
  input logic              reset,
  input logic              dump_valid,
  input logic              dump_ready,
  input logic [DATA_W-1:0] dump_data,
  input logic [ADDR_W-1:0] dump_index,
  input logic              dump_last,
  input logic              busy,
  input logic              done
);

  // An offered word must not change or be withdrawn until it is accepted
  a_hold_stable: assert property (@(posedge clk1) disable iff (reset)
    (dump_valid && !dump_ready) |=> (dump_valid && $stable(dump_data) &&
                                     $stable(dump_index) && $stable(dump_last)));

  a_busy_done_excl: assert property (@(posedge clk1) disable iff (reset)
    !(busy && done));

  a_last_needs_valid: assert property (@(posedge clk1) disable iff (reset)
    dump_last |-> dump_valid);

  a_valid_while_busy: assert property (@(posedge clk1) disable iff (reset)
    dump_valid |-> busy);

endmodule

// File: rtl/reg_dump_unit.sv
// Streams the halted processor's register file out over valid/ready, one word per READ/HOLD pair.
module reg_dump_unit #(
  parameter int DATA_W     = mips32_pkg::DATA_W,
  parameter int ADDR_W     = mips32_pkg::REG_ADDR_W,
  parameter int DUMP_COUNT = mips32_pkg::NUM_REGS,
  parameter int BASE_REG   = 0
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              halted,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);
  import mips32_pkg::*;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DUMP_COUNT - 1);

  dump_state_e       state_r;
  logic [ADDR_W-1:0] idx_r;
  logic              halted_q_r;
  logic              trigger_s;
  logic              accept_s;

  // Rising-edge detect on halted and handshake qualification
  always_comb begin
    trigger_s = halted & ~halted_q_r;
    accept_s  = dump_valid & dump_ready;
  end

  // halted_q resets high so a processor already halted at reset release is not dumped
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      halted_q_r <= 1'b1;
    end else begin
      halted_q_r <= halted;
    end
  end

  // Dump sequencer: the read address is kept registered alongside idx so it never glitches
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      idx_r      <= {ADDR_W{1'b0}};
      rf_rd_addr <= {ADDR_W{1'b0}};
      dump_valid <= 1'b0;
      dump_data  <= {DATA_W{1'b0}};
      dump_index <= {ADDR_W{1'b0}};
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rf_rd_addr <= BASE_ADDR;
          done       <= 1'b0;
          if (trigger_s) begin
            idx_r   <= {ADDR_W{1'b0}};
            busy    <= 1'b1;
            state_r <= READ;
          end else begin
            busy <= 1'b0;
          end
        end
        READ: begin
          dump_data  <= rf_rd_data;
          dump_index <= rf_rd_addr;
          dump_last  <= (idx_r == LAST_IDX);
          dump_valid <= 1'b1;
          state_r    <= HOLD;
        end
        HOLD: begin
          if (accept_s) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (dump_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              // Address arithmetic wraps modulo the register count
              idx_r      <= idx_r + ADDR_W'(1);
              rf_rd_addr <= BASE_ADDR + idx_r + ADDR_W'(1);
              state_r    <= READ;
            end
          end
        end
        DONE: begin
          if (!halted) begin
            done       <= 1'b0;
            idx_r      <= {ADDR_W{1'b0}};
            rf_rd_addr <= BASE_ADDR;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          idx_r      <= {ADDR_W{1'b0}};
          rf_rd_addr <= BASE_ADDR;
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: a default 32-register instance and a wrapping 4-register instance.
module tb_reg_dump_unit;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        reset;
  logic        halted, dump_ready;
  logic [4:0]  rf_rd_addr, dump_index;
  logic [31:0] rf_rd_data, dump_data;
  logic        dump_valid, dump_last, busy, done;
  logic [31:0] rf [32];

  logic        halted_w, ready_w;
  logic [4:0]  w_addr, w_index;
  logic [31:0] w_rdata, w_data;
  logic        w_valid, w_last, w_busy, w_done;
  logic [31:0] rf_w [32];

  assign rf_rd_data = rf[rf_rd_addr];
  assign w_rdata    = rf_w[w_addr];

  reg_dump_unit u_dut (
    .clk1(clk1), .reset(reset), .halted(halted), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_index(dump_index), .dump_last(dump_last),
    .busy(busy), .done(done)
  );

  reg_dump_unit #(.DUMP_COUNT(4), .BASE_REG(30)) u_wrap (
    .clk1(clk1), .reset(reset), .halted(halted_w), .rf_rd_addr(w_addr),
    .rf_rd_data(w_rdata), .dump_valid(w_valid), .dump_ready(ready_w),
    .dump_data(w_data), .dump_index(w_index), .dump_last(w_last),
    .busy(w_busy), .done(w_done)
  );

  reg_dump_unit_chk u_chk (
    .clk1(clk1), .reset(reset), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_index(dump_index), .dump_last(dump_last),
    .busy(busy), .done(done)
  );

  reg_dump_unit_chk u_chk_w (
    .clk1(clk1), .reset(reset), .dump_valid(w_valid), .dump_ready(ready_w),
    .dump_data(w_data), .dump_index(w_index), .dump_last(w_last),
    .busy(w_busy), .done(w_done)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, {31'd0, dump_valid}, 32'd0);
    check_val({tag, "_data"},  dump_data, 32'd0);
    check_val({tag, "_index"}, {27'd0, dump_index}, 32'd0);
    check_val({tag, "_last"},  {31'd0, dump_last}, 32'd0);
    check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check_val({tag, "_done"},  {31'd0, done}, 32'd0);
    check_val({tag, "_addr"},  {27'd0, rf_rd_addr}, 32'd0);
  endtask

  // Waits for the next offered word on the selected instance; every word must arrive 2 cycles after the previous
  task automatic wait_word(input bit wrap, input int k, input logic [4:0] exp_idx,
                           input logic [31:0] exp_data, input logic exp_last);
    int   gap;
    logic v;
    gap = 0;
    v   = 1'b0;
    while (!v && gap < 20) begin
      @(negedge clk1);
      gap++;
      v = wrap ? w_valid : dump_valid;
    end
    check_val($sformatf("w%0d_valid", k), {31'd0, v}, 32'd1);
    check_val($sformatf("w%0d_gap", k), 32'(gap), 32'd2);
    if (wrap) begin
      check_val($sformatf("w%0d_index", k), {27'd0, w_index}, {27'd0, exp_idx});
      check_val($sformatf("w%0d_data", k), w_data, exp_data);
      check_val($sformatf("w%0d_last", k), {31'd0, w_last}, {31'd0, exp_last});
      check_val($sformatf("w%0d_busy", k), {31'd0, w_busy}, 32'd1);
    end else begin
      check_val($sformatf("w%0d_index", k), {27'd0, dump_index}, {27'd0, exp_idx});
      check_val($sformatf("w%0d_data", k), dump_data, exp_data);
      check_val($sformatf("w%0d_last", k), {31'd0, dump_last}, {31'd0, exp_last});
      check_val($sformatf("w%0d_busy", k), {31'd0, busy}, 32'd1);
    end
  endtask

  // Full 32-word dump on the default instance; optional stall index and optional halted drop index
  task automatic run_dump(input logic [31:0] key, input int bp_idx, input int drop_idx);
    for (int k = 0; k < 32; k++) begin
      wait_word(1'b0, k, 5'(k), 32'(k) ^ key, (k == 31));
      if (k == bp_idx) begin
        dump_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk1);
          check_val("bp_valid", {31'd0, dump_valid}, 32'd1);
          check_val("bp_data", dump_data, 32'(k) ^ key);
          check_val("bp_index", {27'd0, dump_index}, 32'(k));
        end
        dump_ready = 1'b1;
      end
      if (k == drop_idx) halted = 1'b0;
    end
  endtask

  int seen;
  logic [4:0]  wrap_idx  [4];
  logic [31:0] wrap_data [4];

  initial begin
    for (int k = 0; k < 32; k++) begin
      rf[k]   = 32'(k);
      rf_w[k] = 32'h0000_0000;
    end
    rf_w[30] = 32'h0000_00AA;
    rf_w[31] = 32'h0000_00BB;
    rf_w[1]  = 32'h0000_0011;
    wrap_idx[0] = 5'd30; wrap_idx[1] = 5'd31; wrap_idx[2] = 5'd0; wrap_idx[3] = 5'd1;
    wrap_data[0] = 32'hAA; wrap_data[1] = 32'hBB; wrap_data[2] = 32'h00; wrap_data[3] = 32'h11;

    reset = 1'b1; halted = 1'b1; halted_w = 1'b0; dump_ready = 1'b1; ready_w = 1'b1;
    repeat (3) @(negedge clk1);
    check_zero("rst");

    // Halted already high across reset release: no dump
    reset = 1'b0;
    seen  = 0;
    repeat (10) begin
      @(negedge clk1);
      if (dump_valid) seen++;
    end
    check_val("hi_at_rst_words", 32'(seen), 32'd0);
    check_val("hi_at_rst_busy", {31'd0, busy}, 32'd0);
    halted = 1'b0;
    repeat (2) @(negedge clk1);

    // Basic dump with a 5-cycle stall on index 3
    halted = 1'b1;
    run_dump(32'h0, 3, -1);
    @(negedge clk1);
    check_val("done1", {31'd0, done}, 32'd1);
    check_val("done1_busy", {31'd0, busy}, 32'd0);
    check_val("done1_valid", {31'd0, dump_valid}, 32'd0);

    // Halted held high after done: no repeat dump
    seen = 0;
    repeat (10) begin
      @(negedge clk1);
      if (dump_valid) seen++;
    end
    check_val("rearm_words", 32'(seen), 32'd0);
    check_val("rearm_done", {31'd0, done}, 32'd1);
    halted = 1'b0;
    @(negedge clk1);
    check_val("rearm_clear", {31'd0, done}, 32'd0);

    // Second dump with new contents; halted drops mid-dump and is ignored
    for (int k = 0; k < 32; k++) rf[k] = 32'(k) ^ 32'hA5A5_0000;
    halted = 1'b1;
    run_dump(32'hA5A5_0000, -1, 10);
    @(negedge clk1);
    check_val("done2", {31'd0, done}, 32'd1);
    @(negedge clk1);
    check_val("done2_exit", {31'd0, done}, 32'd0);

    // Reset while holding index 7
    for (int k = 0; k < 32; k++) rf[k] = 32'(k);
    halted = 1'b1;
    for (int k = 0; k < 8; k++) wait_word(1'b0, k, 5'(k), 32'(k), 1'b0);
    dump_ready = 1'b0;
    @(negedge clk1);
    check_val("stall7_index", {27'd0, dump_index}, 32'd7);
    reset = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk1);
    reset = 1'b0;
    dump_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk1);
      if (dump_valid) seen++;
    end
    check_val("post_rst_words", 32'(seen), 32'd0);
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);

    // Wrapping instance: addresses 30,31,0,1
    halted_w = 1'b1;
    for (int k = 0; k < 4; k++) wait_word(1'b1, k, wrap_idx[k], wrap_data[k], (k == 3));
    @(negedge clk1);
    check_val("wrap_done", {31'd0, w_done}, 32'd1);
    check_val("wrap_valid_off", {31'd0, w_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
